epb_master: RTL and testbench
=============================

# epb_master

EPB bus initiator driven from an 8-bit Wishbone slave port. It turns each Wishbone access into one PowerPC-style EPB cycle (`cs_n`, `oe_n`, `we_n`, address, data) and waits for the target's `rdy`. It is the counterpart of `epb_wb_bridge`: the same EPB protocol, seen from the processor side. It serves as a bus-functional master in CPLD testbenches and lets a Wishbone host reach EPB-attached peripherals.

## Interface
Parameters:
- `ADDR_W`, 6: EPB/Wishbone address width.
- `SETUP_CYC`, 1: cycles `cs_n` and address are valid before a strobe. Range 1..15.
- `HOLD_CYC`, 1: cycles `cs_n`, address and write data are held after the strobe is released. Range 1..15.
- `TIMEOUT`, 255: maximum strobe cycles spent waiting for `rdy`. Range 1..255.

Ports:
- `wb_clk_i` in 1: the single clock.
- `wb_rst_n` in 1: reset. Synchronous, active-low.
- `wb_cyc_i`, `wb_stb_i`, `wb_we_i` in 1 each: Wishbone request.
- `wb_adr_i` in ADDR_W: address.
- `wb_dat_i` in 8: write data.
- `wb_dat_o` out 8: read data.
- `wb_ack_o` out 1: one-cycle completion pulse.
- `wb_err_o` out 1: one-cycle timeout completion pulse.
- `epb_cs_n`, `epb_oe_n`, `epb_we_n` out 1 each: EPB controls, active-low.
- `epb_addr` out ADDR_W: EPB address.
- `epb_data_o` out 8: EPB write data.
- `epb_data_oe` out 1: enable for the external data tri-state buffer.
- `epb_data_i` in 8: EPB read data.
- `epb_rdy_i` in 1: target ready, active-high, sampled synchronously.

## Operation
- All outputs are registered.
- Reset values: `epb_cs_n`, `epb_oe_n` and `epb_we_n` = 1. `epb_addr`, `epb_data_o`, `wb_dat_o` = 0. `epb_data_oe`, `wb_ack_o`, `wb_err_o` = 0.
- FSM states are IDLE, SETUP, STROBE, HOLD and DONE.
- **IDLE:** when `wb_cyc_i & wb_stb_i` is sampled, latch address, `we` and write data, load the cycle counter with SETUP_CYC, and go to SETUP. Requests are only accepted in IDLE.
- **SETUP:**
  - `cs_n`=0 and `epb_addr` valid.
  - For writes, `epb_data_oe`=1 with `epb_data_o` valid.
  - Strobes stay high.
  - When the counter expires, go to STROBE and clear the timeout counter.
- **STROBE:**
  - `oe_n`=0 for reads, `we_n`=0 for writes.
  - When `epb_rdy_i`=1 is sampled: capture `epb_data_i` into `wb_dat_o` (reads only) and go to HOLD.
  - If `rdy` is still low after TIMEOUT strobe cycles: set the error flag, force `wb_dat_o`=8'hFF on reads, and go to HOLD.
- **HOLD:**
  - Strobes high; `cs_n`, address and write data held.
  - After HOLD_CYC cycles go to DONE.
- **DONE:**
  - `cs_n`=1, `epb_data_oe`=0.
  - Pulse `wb_ack_o` (normal) or `wb_err_o` (timeout) for exactly one cycle. Never both.
  - Return to IDLE.
- Because requests are sampled only in IDLE, there is always at least one cycle with `cs_n` high between EPB cycles (bus turnaround).
- **Simultaneous events:** `rdy` arriving on the same cycle the timeout expires counts as success. No error is raised.
- **`wb_cyc_i` dropped mid-cycle:** the EPB cycle always runs to completion. Ack/err is suppressed if `wb_cyc_i`=0 in DONE.
- **Reset mid-cycle:** all outputs return to their reset values on the next edge and the FSM goes to IDLE. No ack is issued.
- `oe_n` and `we_n` are never low together. `epb_data_oe` is never 1 during a read.

## Timing
- Request sampled at cycle t. Then:
  - t+1: `cs_n` falls.
  - t+1+SETUP_CYC: strobe falls.
- `rdy` sampled high at cycle r:
  - r+1: strobe rises.
  - r+1+HOLD_CYC: DONE, `cs_n` rises, ack pulses.
- Minimum latency (SETUP=HOLD=1, `rdy` seen in the first strobe cycle): ack at t+4.
- Next request can be accepted at t+5.
- Timeout case: ack/err at t+1+SETUP_CYC+TIMEOUT+HOLD_CYC.
- `wb_dat_o` is stable from the HOLD entry until the next read captures.

## Structure
- Shared package `epb_pkg` holds:
  - FSM state encoding (3-bit, one localparam per state);
  - the timeout read value 8'hFF;
  - the counter width (4 bits for setup/hold, 8 bits for timeout).
- One sub-module, `epb_delay_cnt`: loadable down-counter with a `done` flag, used for setup, hold and timeout.
- Everything else stays flat.

## Test plan
- **Write:** adr=0x15, dat=0xA5, `rdy` tied high.
  - `cs_n` low at t+1, `we_n` low at t+2 only, `epb_data_oe`=1 from t+1 to t+3, `epb_data_o`=0xA5.
  - `wb_ack_o` single pulse at t+4; `oe_n` never low.
- **Read with late ready:** adr=0x3F, `rdy` asserted 5 cycles after the strobe, `epb_data_i`=0x5C.
  - `wb_dat_o`=0x5C, ack at t+1+1+6+1.
  - `epb_data_oe` stays 0 throughout.
- **Timeout:** TIMEOUT=8, `rdy` held low.
  - `wb_err_o` pulse only (no ack), `wb_dat_o`=0xFF, `cs_n` high at the DONE cycle.
  - Second case: `rdy` rising exactly on the 8th strobe cycle gives ack, not err.
- **Back-to-back:** `stb` held high across two requests.
  - At least one `cs_n`-high cycle between the EPB cycles; two acks.
  - Parameter sweep: SETUP=3, HOLD=2 gives strobe at t+4 and ack at r+3.
- **Reset and abort:**
  - `wb_rst_n` driven low during STROBE: all outputs at reset values next edge, no ack, next request served normally.
  - `wb_cyc_i` dropped during SETUP: the EPB cycle completes, no ack.

Source files
------------

// File: rtl/epb_pkg.sv
// rtl/epb_pkg.sv - shared state encoding, counter widths and constants for the EPB initiator
package epb_pkg;

   localparam logic [2:0] ST_IDLE   = 3'd0;
   localparam logic [2:0] ST_SETUP  = 3'd1;
   localparam logic [2:0] ST_STROBE = 3'd2;
   localparam logic [2:0] ST_HOLD   = 3'd3;
   localparam logic [2:0] ST_DONE   = 3'd4;

   typedef enum logic [2:0] {
      IDLE   = ST_IDLE,
      SETUP  = ST_SETUP,
      STROBE = ST_STROBE,
      HOLD   = ST_HOLD,
      DONE   = ST_DONE
   } state_t;

   localparam logic [7:0] TIMEOUT_RDATA = 8'hFF;
   localparam int         PHASE_CNT_W   = 4;
   localparam int         TMO_CNT_W     = 8;

endpackage

// File: rtl/epb_delay_cnt.sv
// rtl/epb_delay_cnt.sv - loadable down-counter; done marks the last cycle of a loaded interval
module epb_delay_cnt #(
   parameter int W = 4
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         load,
   input  logic [W-1:0] load_val,
   input  logic         en,
   output logic         done
);

   logic [W-1:0] cnt;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         cnt <= '0;
      end else if (load) begin
         cnt <= load_val;
      end else if (en && cnt != '0) begin
         cnt <= cnt - 1'b1;
      end
   end

   // A load of N yields N cycles; done is high during the Nth one.
   assign done = (cnt <= W'(1));

endmodule

// File: rtl/epb_master.sv
// rtl/epb_master.sv - Wishbone slave to EPB initiator, one EPB cycle per Wishbone access
module epb_master
   import epb_pkg::*;
#(
   parameter int ADDR_W    = 6,
   parameter int SETUP_CYC = 1,
   parameter int HOLD_CYC  = 1,
   parameter int TIMEOUT   = 255
) (
   input  logic              wb_clk_i,
   input  logic              wb_rst_n,
   input  logic              wb_cyc_i,
   input  logic              wb_stb_i,
   input  logic              wb_we_i,
   input  logic [ADDR_W-1:0] wb_adr_i,
   input  logic [7:0]        wb_dat_i,
   output logic [7:0]        wb_dat_o,
   output logic              wb_ack_o,
   output logic              wb_err_o,
   output logic              epb_cs_n,
   output logic              epb_oe_n,
   output logic              epb_we_n,
   output logic [ADDR_W-1:0] epb_addr,
   output logic [7:0]        epb_data_o,
   output logic              epb_data_oe,
   input  logic [7:0]        epb_data_i,
   input  logic              epb_rdy_i
);

   state_t                   state, next_state;
   logic                     we_q, err_q;
   logic                     ph_load, ph_done, tmo_load, tmo_done;
   logic [PHASE_CNT_W-1:0]   ph_val;
   logic                     we_nx, busy_nx;

   epb_delay_cnt #(.W(PHASE_CNT_W)) u_phase_cnt (
      .clk      (wb_clk_i),
      .rst_n    (wb_rst_n),
      .load     (ph_load),
      .load_val (ph_val),
      .en       (state == SETUP || state == HOLD),
      .done     (ph_done)
   );

   epb_delay_cnt #(.W(TMO_CNT_W)) u_tmo_cnt (
      .clk      (wb_clk_i),
      .rst_n    (wb_rst_n),
      .load     (tmo_load),
      .load_val (TMO_CNT_W'(TIMEOUT)),
      .en       (state == STROBE),
      .done     (tmo_done)
   );

   always_comb begin
      next_state = state;
      ph_load    = 1'b0;
      ph_val     = PHASE_CNT_W'(SETUP_CYC);
      tmo_load   = 1'b0;
      case (state)
         IDLE: if (wb_cyc_i && wb_stb_i) begin
            next_state = SETUP;
            ph_load    = 1'b1;
         end
         SETUP: if (ph_done) begin
            next_state = STROBE;
            tmo_load   = 1'b1;
         end
         // A ready on the final timeout cycle still wins.
         STROBE: if (epb_rdy_i || tmo_done) begin
            next_state = HOLD;
            ph_load    = 1'b1;
            ph_val     = PHASE_CNT_W'(HOLD_CYC);
         end
         HOLD: if (ph_done) next_state = DONE;
         DONE:    next_state = IDLE;
         default: next_state = IDLE;
      endcase
   end

   assign we_nx   = (state == IDLE) ? wb_we_i : we_q;
   assign busy_nx = (next_state == SETUP) || (next_state == STROBE) || (next_state == HOLD);

   always_ff @(posedge wb_clk_i) begin
      if (!wb_rst_n) begin
         state       <= IDLE;
         we_q        <= 1'b0;
         err_q       <= 1'b0;
         wb_dat_o    <= '0;
         wb_ack_o    <= 1'b0;
         wb_err_o    <= 1'b0;
         epb_cs_n    <= 1'b1;
         epb_oe_n    <= 1'b1;
         epb_we_n    <= 1'b1;
         epb_addr    <= '0;
         epb_data_o  <= '0;
         epb_data_oe <= 1'b0;
      end else begin
         state       <= next_state;
         wb_ack_o    <= 1'b0;
         wb_err_o    <= 1'b0;
         epb_cs_n    <= ~busy_nx;
         epb_oe_n    <= ~(next_state == STROBE && !we_nx);
         epb_we_n    <= ~(next_state == STROBE && we_nx);
         epb_data_oe <= busy_nx && we_nx;
         if (state == IDLE && wb_cyc_i && wb_stb_i) begin
            epb_addr   <= wb_adr_i;
            epb_data_o <= wb_dat_i;
            we_q       <= wb_we_i;
            err_q      <= 1'b0;
         end
         if (state == STROBE && !epb_rdy_i && tmo_done) err_q <= 1'b1;
         if (state == STROBE && !we_q) begin
            if (epb_rdy_i)     wb_dat_o <= epb_data_i;
            else if (tmo_done) wb_dat_o <= TIMEOUT_RDATA;
         end
         // Completion is reported only to a master that still holds the cycle.
         if (state == HOLD && ph_done) begin
            wb_ack_o <= wb_cyc_i & ~err_q;
            wb_err_o <= wb_cyc_i & err_q;
         end
      end
   end

endmodule

// File: tb/tb_epb_master.sv
// tb/tb_epb_master.sv - scoreboard bench for epb_master with a behavioural EPB target model
module tb_epb_master;

   localparam int AW = 6, SETUP = 1, HOLD = 1, TMO = 8;

   logic          clk = 1'b0;
   always #5 clk = ~clk;

   logic          wb_rst_n = 1'b0;
   logic          wb_cyc_i = 1'b0, wb_stb_i = 1'b0, wb_we_i = 1'b0;
   logic [AW-1:0] wb_adr_i = '0;
   logic [7:0]    wb_dat_i = '0;
   logic [7:0]    wb_dat_o;
   logic          wb_ack_o, wb_err_o;
   logic          epb_cs_n, epb_oe_n, epb_we_n, epb_data_oe;
   logic [AW-1:0] epb_addr;
   logic [7:0]    epb_data_o;
   logic [7:0]    epb_data_i = '0;
   logic          epb_rdy_i = 1'b0;

   logic          s_cyc = 1'b0, s_stb = 1'b0, s_we = 1'b0;
   logic [AW-1:0] s_adr = '0;
   logic [7:0]    s_dat = '0;
   logic [7:0]    s_dat_o, s_data_o;
   logic          s_ack, s_err, s_cs_n, s_oe_n, s_we_n, s_data_oe;
   logic [AW-1:0] s_addr;
   logic [7:0]    s_data_i = 8'h00;
   logic          s_rdy = 1'b1;

   epb_master #(.ADDR_W(AW), .SETUP_CYC(SETUP), .HOLD_CYC(HOLD), .TIMEOUT(TMO)) dut (
      .wb_clk_i(clk), .wb_rst_n(wb_rst_n), .wb_cyc_i(wb_cyc_i), .wb_stb_i(wb_stb_i),
      .wb_we_i(wb_we_i), .wb_adr_i(wb_adr_i), .wb_dat_i(wb_dat_i), .wb_dat_o(wb_dat_o),
      .wb_ack_o(wb_ack_o), .wb_err_o(wb_err_o), .epb_cs_n(epb_cs_n), .epb_oe_n(epb_oe_n),
      .epb_we_n(epb_we_n), .epb_addr(epb_addr), .epb_data_o(epb_data_o),
      .epb_data_oe(epb_data_oe), .epb_data_i(epb_data_i), .epb_rdy_i(epb_rdy_i));

   epb_master #(.ADDR_W(AW), .SETUP_CYC(3), .HOLD_CYC(2), .TIMEOUT(TMO)) dut_s (
      .wb_clk_i(clk), .wb_rst_n(wb_rst_n), .wb_cyc_i(s_cyc), .wb_stb_i(s_stb),
      .wb_we_i(s_we), .wb_adr_i(s_adr), .wb_dat_i(s_dat), .wb_dat_o(s_dat_o),
      .wb_ack_o(s_ack), .wb_err_o(s_err), .epb_cs_n(s_cs_n), .epb_oe_n(s_oe_n),
      .epb_we_n(s_we_n), .epb_addr(s_addr), .epb_data_o(s_data_o),
      .epb_data_oe(s_data_oe), .epb_data_i(s_data_i), .epb_rdy_i(s_rdy));

   typedef struct { bit is_err; logic [7:0] dat; int t; int lat; } wb_exp_t;
   typedef struct { bit we; logic [AW-1:0] addr; logic [7:0] wdata; logic [7:0] rdata;
                    int delay; int scyc; } epb_exp_t;

   wb_exp_t    wb_q[$];
   epb_exp_t   epb_q[$];
   int         checks = 0, errors = 0;
   int         cyc = 0;
   int         last_ack = -100;
   logic [7:0] last_read = 8'h00;
   bit         skip_len = 0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic check_reset_vals();
      chk("rst_cs_n", epb_cs_n, 1);  chk("rst_oe_n", epb_oe_n, 1);  chk("rst_we_n", epb_we_n, 1);
      chk("rst_addr", epb_addr, 0);  chk("rst_data_o", epb_data_o, 0);
      chk("rst_dat_o", wb_dat_o, 0); chk("rst_data_oe", epb_data_oe, 0);
      chk("rst_ack", wb_ack_o, 0);   chk("rst_err", wb_err_o, 0);
   endtask

   // EPB target: raises rdy on strobe cycle index 'delay' and checks the cycle it sees.
   epb_exp_t cur;
   bit       in_strobe = 0, cs_fell = 0, strobe;
   logic     prev_cs = 1'b1;
   int       scnt = 0;
   always @(negedge clk) begin
      strobe = !epb_oe_n || !epb_we_n;
      chk("oe_we_excl", !epb_oe_n && !epb_we_n, 0);
      chk("read_no_drive", epb_data_oe && !epb_oe_n, 0);
      chk("idle_quiet", epb_cs_n && (epb_data_oe || strobe), 0);
      if (prev_cs && !epb_cs_n) cs_fell = 1;
      prev_cs = epb_cs_n;
      if (strobe && !in_strobe) begin
         in_strobe = 1;
         scnt = 0;
         if (epb_q.size() == 0) begin
            checks++; errors++;
            $display("FAIL unexpected_strobe: got strobe expected none (cycle %0d)", cyc);
         end else cur = epb_q.pop_front();
         chk("turnaround", cs_fell, 1);
         cs_fell = 0;
         chk("epb_dir", !epb_we_n, cur.we);
         chk("epb_addr", epb_addr, cur.addr);
         chk("epb_data_oe", epb_data_oe, cur.we);
         if (cur.we) chk("epb_wdata", epb_data_o, cur.wdata);
      end
      if (strobe) begin
         epb_rdy_i  = (scnt >= cur.delay);
         epb_data_i = cur.rdata;
         scnt++;
      end else begin
         if (in_strobe && !skip_len) chk("strobe_len", scnt, cur.scyc);
         in_strobe  = 0;
         skip_len   = 0;
         epb_rdy_i  = 1'b0;
         epb_data_i = 8'($urandom);
      end
   end

   always @(negedge clk) begin
      wb_exp_t e;
      chk("ack_err_excl", wb_ack_o & wb_err_o, 0);
      if (wb_ack_o || wb_err_o) begin
         if (wb_q.size() == 0) begin
            checks++; errors++;
            $display("FAIL unexpected_resp: got ack=%0b err=%0b expected none", wb_ack_o, wb_err_o);
         end else begin
            e = wb_q.pop_front();
            chk("resp_ack", wb_ack_o, !e.is_err);
            chk("resp_err", wb_err_o, e.is_err);
            chk("resp_latency", cyc - e.t, e.lat);
            chk("resp_rdata", wb_dat_o, e.dat);
            chk("done_cs_n", epb_cs_n, 1);
            chk("done_data_oe", epb_data_oe, 0);
         end
      end
   end

   task automatic post(input bit we, input logic [AW-1:0] a, input logic [7:0] wd,
                       input logic [7:0] rd, input int dly, input int gap, input bit expect_resp);
      bit ok;
      int scyc, t;
      if (gap > 0) begin
         wb_cyc_i = 0; wb_stb_i = 0;
         repeat (gap) @(negedge clk);
      end
      wb_cyc_i = 1; wb_stb_i = 1; wb_we_i = we; wb_adr_i = a; wb_dat_i = wd;
      t    = (cyc > last_ack) ? cyc : last_ack + 1;
      ok   = dly < TMO;
      scyc = ok ? dly + 1 : TMO;
      if (!we) last_read = ok ? rd : 8'hFF;
      epb_q.push_back('{we, a, wd, rd, dly, scyc});
      if (expect_resp) wb_q.push_back('{!ok, last_read, t, 1 + SETUP + scyc + HOLD});
   endtask

   task automatic xact(input bit we, input logic [AW-1:0] a, input logic [7:0] wd,
                       input logic [7:0] rd, input int dly, input int gap);
      int n = 0;
      post(we, a, wd, rd, dly, gap, 1);
      do begin
         @(negedge clk);
         n++;
      end while (!(wb_ack_o || wb_err_o) && n < 200);
      if (n >= 200) begin
         checks++; errors++;
         $display("FAIL resp_timeout: got no response expected one within 200 cycles");
      end
      last_ack = cyc;
   endtask

   initial begin
      int n, t, strobe_c, ack_c, dly, r;
      repeat (3) @(negedge clk);
      check_reset_vals();
      wb_rst_n = 1;
      @(negedge clk);

      xact(1, 6'h15, 8'hA5, 8'h00, 0, 1);
      xact(0, 6'h3F, 8'h00, 8'h5C, 5, 1);
      xact(0, 6'h0A, 8'h00, 8'h77, 100, 1);
      xact(0, 6'h0B, 8'h00, 8'h81, TMO - 1, 1);
      xact(1, 6'h01, 8'h11, 8'h00, 0, 1);
      xact(1, 6'h02, 8'h22, 8'h00, 2, 0);
      xact(1, 6'h05, 8'h66, 8'h00, TMO, 1);

      // Master abandons the access during SETUP; EPB cycle must still finish silently.
      post(0, 6'h21, 8'h00, 8'h9D, 1, 2, 0);
      @(negedge clk);
      wb_cyc_i = 0; wb_stb_i = 0;
      repeat (10) @(negedge clk);
      chk("abort_bus_idle", epb_cs_n, 1);

      // Reset in the middle of a strobe.
      post(0, 6'h33, 8'h00, 8'h44, 6, 1, 1);
      n = 0;
      while (epb_oe_n && n < 20) begin @(negedge clk); n++; end
      chk("reached_strobe", epb_oe_n, 0);
      @(negedge clk);
      wb_rst_n = 0; skip_len = 1;
      @(negedge clk);
      check_reset_vals();
      wb_q.delete();
      last_read = 8'h00;
      wb_rst_n = 1; wb_cyc_i = 0; wb_stb_i = 0;
      @(negedge clk);
      xact(0, 6'h12, 8'h00, 8'hC3, 1, 1);

      for (int i = 0; i < 40; i++) begin
         r   = $urandom_range(0, 9);
         dly = (r < 6) ? $urandom_range(0, 3) : (r == 6) ? TMO - 1 : (r == 7) ? TMO : $urandom_range(4, 12);
         xact(1'($urandom_range(0, 1)), AW'($urandom), 8'($urandom), 8'($urandom), dly,
              $urandom_range(0, 2));
      end
      wb_cyc_i = 0; wb_stb_i = 0;

      // SETUP_CYC=3, HOLD_CYC=2 instance with ready tied high.
      @(negedge clk);
      s_cyc = 1; s_stb = 1; s_we = 1; s_adr = 6'h2A; s_dat = 8'h3C;
      t = cyc; strobe_c = -1; ack_c = -1;
      for (int i = 0; i < 30 && ack_c < 0; i++) begin
         @(negedge clk);
         if (!s_we_n && strobe_c < 0) strobe_c = cyc;
         if (s_ack) ack_c = cyc;
      end
      s_cyc = 0; s_stb = 0;
      chk("sweep_strobe_at", strobe_c - t, 4);
      chk("sweep_ack_after_rdy", ack_c - strobe_c, 3);

      repeat (5) @(negedge clk);
      chk("wb_q_drained", wb_q.size(), 0);
      chk("epb_q_drained", epb_q.size(), 0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: got no finish expected finish before 500000 ns");
      $fatal(1);
   end

endmodule
